target_spawner: RTL

- Consumer end of the latched-random-number interface. It drives the `rise` request pin of a random-latch generator and reads back its `dout` value.
- Converts the sampled value into a target Y spawn coordinate.
- Rejects out-of-range values and values recently used, retrying a bounded number of times.
- Presents the accepted coordinate to the game controller with a valid/ack handshake.

---
 rtl/target_spawner_pkg.sv | 20 ++
 rtl/spawn_history.sv | 50 +++++
 rtl/target_spawner.sv | 136 +++++++++++++
 3 files changed

// File: rtl/target_spawner_pkg.sv
// Shared types and helpers for the target spawner: FSM state encoding and
// slot-index to screen-Y conversion.
package target_spawner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RISE,
    ST_WAIT,
    ST_CHECK,
    ST_PRESENT
  } state_e;

  // Evaluated at 32 bits; callers narrow to their Y width once the range is proven.
  function automatic logic [31:0] slot_to_y(input logic [31:0] idx,
                                            input logic [31:0] base,
                                            input logic [31:0] step);
    return base + idx * step;
  endfunction

endpackage

// File: rtl/spawn_history.sv
// Shift register of recently spawned slot indices with per-entry valid bits
// and a combinational membership query.
module spawn_history #(
  parameter int IDX_W      = 5,
  parameter int HIST_DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             clear,
  input  logic [IDX_W-1:0] query_idx,
  output logic             hit
);

  logic [IDX_W-1:0]      ent_q [HIST_DEPTH];
  logic [IDX_W-1:0]      ent_d [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] vld_q, vld_d;

  // A clear in the same cycle as a push wipes the old entries first, then the push lands.
  always_comb begin
    ent_d = ent_q;
    vld_d = clear ? '0 : vld_q;
    if (push) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) begin
        ent_d[i] = ent_q[i-1];
        vld_d[i] = clear ? 1'b0 : vld_q[i-1];
      end
      ent_d[0] = push_idx;
      vld_d[0] = 1'b1;
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      if (vld_q[i] && (ent_q[i] == query_idx)) hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

endmodule

// File: rtl/target_spawner.sv
// Requests a latched random value, rejects out-of-range or recently used slots
// with bounded retries, and presents the chosen spawn Y under valid/ack.
module target_spawner
  import target_spawner_pkg::*;
#(
  parameter int RND_BITS   = 5,
  parameter int MAX_IDX    = 5,
  parameter int HIST_DEPTH = 3,
  parameter int MAX_RETRY  = 4,
  parameter int BASE_Y     = 200,
  parameter int STEP_Y     = 40,
  parameter int Y_BITS     = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spawn_req,
  input  logic                clear_hist,
  input  logic [RND_BITS-1:0] rnd_val,
  output logic                rnd_rise,
  output logic                spawn_valid,
  input  logic                spawn_ack,
  output logic [Y_BITS-1:0]   spawn_y,
  output logic [RND_BITS-1:0] spawn_idx,
  output logic                spawn_forced,
  output logic                busy
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int Y_MAX   = BASE_Y + MAX_IDX * STEP_Y;

  state_e                state_q, state_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic [RND_BITS-1:0]   cand_q, cand_d;
  logic                  valid_q, valid_d;
  logic [RND_BITS-1:0]   idx_q, idx_d;
  logic [Y_BITS-1:0]     y_q, y_d;
  logic                  forced_q, forced_d;
  logic                  hist_hit, hist_push, over, bad;
  logic [RND_BITS-1:0]   pick_idx;

  spawn_history #(
    .IDX_W      (RND_BITS),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk       (clk),
    .reset     (reset),
    .push      (hist_push),
    .push_idx  (idx_q),
    .clear     (clear_hist),
    .query_idx (cand_q),
    .hit       (hist_hit)
  );

  assign over     = cand_q > RND_BITS'(MAX_IDX);
  assign bad      = over || hist_hit;
  assign pick_idx = over ? RND_BITS'(MAX_IDX) : cand_q;

  // The generator latches on the rising edge of this decode; CHECK keeps it low
  // so every retry produces a fresh edge.
  assign rnd_rise     = (state_q == ST_RISE) || (state_q == ST_WAIT);
  assign busy         = (state_q != ST_IDLE);
  assign spawn_valid  = valid_q;
  assign spawn_idx    = idx_q;
  assign spawn_y      = y_q;
  assign spawn_forced = forced_q;

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    cand_d    = cand_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    y_d       = y_q;
    forced_d  = forced_q;
    hist_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (spawn_req) begin
          retry_d = '0;
          state_d = ST_RISE;
        end
      end
      ST_RISE: state_d = ST_WAIT;
      ST_WAIT: begin
        cand_d  = rnd_val;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (bad && (retry_q < RETRY_W'(MAX_RETRY))) begin
          retry_d = retry_q + 1'b1;
          state_d = ST_RISE;
        end else begin
          idx_d    = pick_idx;
          y_d      = Y_BITS'(slot_to_y(32'(pick_idx), 32'(BASE_Y), 32'(STEP_Y)));
          forced_d = bad;
          valid_d  = 1'b1;
          state_d  = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (spawn_ack) begin
          hist_push = 1'b1;
          valid_d   = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      retry_q  <= '0;
      cand_q   <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      y_q      <= '0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      cand_q   <= cand_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      y_q      <= y_d;
      forced_q <= forced_d;
    end
  end

  always_ff @(posedge clk) begin
    assert (Y_MAX < (1 << Y_BITS))
      else $error("BASE_Y + MAX_IDX*STEP_Y does not fit in Y_BITS");
  end

endmodule
